// File: rtl/button_pulse_pkg.sv
// Shared constants and types for the button conditioner.
// Default timings target the 25 MHz board clock.
package button_pulse_pkg;

    // 10 ms debounce, 0.5 s first repeat, 0.1 s repeat rate
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int REPEAT_DELAY_DEF    = 12500000;
    localparam int REPEAT_PERIOD_DEF   = 2500000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus debounce counter for one raw button.
// LEVEL follows SW only after it has differed for DEBOUNCE_CYCLES cycles.
module debounce_filter
    import button_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW,
    output logic LEVEL
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // bring the asynchronous button level into the CLK domain
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
        end
    end

    // accept a new level only after an uninterrupted run of differing samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= '0;
            LEVEL <= 1'b0;
        end else if (sync2 == LEVEL) begin
            cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
            LEVEL <= sync2;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_pulse.sv
// Turns a bouncy button into single-cycle increment pulses,
// with optional hold-to-auto-repeat, and exports the debounced level.
module button_pulse
    import button_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW,
    output logic PULSE,
    output logic LEVEL
);

    localparam int TW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    state_t        state;
    logic [TW-1:0] timer;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK  (CLK),
        .RST  (RST),
        .SW   (SW),
        .LEVEL(LEVEL)
    );

    // press/repeat sequencer; release is checked before timer expiry
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            timer <= '0;
            PULSE <= 1'b0;
        end else begin
            PULSE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (LEVEL) begin
                        PULSE <= 1'b1;
                        timer <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!LEVEL) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (REPEAT_EN && timer == DLY_LAST) begin
                        PULSE <= 1'b1;
                        timer <= '0;
                        state <= REPEAT;
                    end else if (REPEAT_EN) begin
                        timer <= timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!LEVEL) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (timer == PER_LAST) begin
                        PULSE <= 1'b1;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_pulse.sv
// Directed and randomized bench for button_pulse, with and without
// auto-repeat, against a sample-window / hold-length reference model.
module tb_button_pulse;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic CLK = 1'b0;
    logic RST;
    logic SW;
    logic p0, l0, p1, l1;

    always #5 CLK = ~CLK;

    button_pulse #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (1'b0)
    ) u_dut0 (
        .CLK  (CLK),
        .RST  (RST),
        .SW   (SW),
        .PULSE(p0),
        .LEVEL(l0)
    );

    button_pulse #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (1'b1)
    ) u_dut1 (
        .CLK  (CLK),
        .RST  (RST),
        .SW   (SW),
        .PULSE(p1),
        .LEVEL(l1)
    );

    // reference model state
    logic ms1, ms2, mlvl;
    logic win[$];
    int   mh[2];
    logic mp[2];

    int vectors = 0;
    int miscompares = 0;
    int stepn = 0;
    int cnt0 = 0;
    int cnt1 = 0;

    // one clock edge of the reference model
    task automatic model_edge(input logic rst, input logic sw);
        logic old_lvl;
        logic all_diff;
        int   k;
        if (rst) begin
            ms1  = 1'b0;
            ms2  = 1'b0;
            mlvl = 1'b0;
            win.delete();
            for (int e = 0; e < 2; e++) begin
                mh[e] = 0;
                mp[e] = 1'b0;
            end
            return;
        end
        old_lvl = mlvl;
        // level flips once the last D synced samples all disagree with it
        win.push_back(ms2);
        if (win.size() > D) void'(win.pop_front());
        if (win.size() == D) begin
            all_diff = 1'b1;
            foreach (win[i]) if (win[i] == mlvl) all_diff = 1'b0;
            if (all_diff) mlvl = ~mlvl;
        end
        // pulse on first held cycle, then at RD, RD+RP, RD+2RP ...
        for (int e = 0; e < 2; e++) begin
            if (old_lvl) begin
                mh[e]++;
                k = mh[e] - 1;
                mp[e] = (k == 0) ||
                        (e == 1 && k >= RD && (k - RD) % RP == 0);
            end else begin
                mh[e] = 0;
                mp[e] = 1'b0;
            end
        end
        ms2 = ms1;
        ms1 = sw;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %b expected %b",
                   tag, stepn, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic sw);
        RST = rst;
        SW  = sw;
        @(posedge CLK);
        model_edge(rst, sw);
        #1;
        stepn++;
        chk("pulse_en0", p0, mp[0]);
        chk("pulse_en1", p1, mp[1]);
        chk("level_en0", l0, mlvl);
        chk("level_en1", l1, mlvl);
        if (p0 === 1'b1) cnt0++;
        if (p1 === 1'b1) cnt1++;
    endtask

    task automatic run(input int n, input logic sw);
        for (int i = 0; i < n; i++) step(1'b0, sw);
    endtask

    initial begin
        int len;
        logic lv;
        logic rr;
        RST = 1'b1;
        SW  = 1'b0;

        // reset held 3 cycles with SW toggling
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i[0]);
            chk("rst_pulse", p1, 1'b0);
            chk("rst_level", l1, 1'b0);
        end
        step(1'b0, 1'b0);
        chk("post_rst_level", l0, 1'b0);
        run(6, 1'b0);

        // clean press held 8 cycles
        cnt0 = 0; cnt1 = 0;
        run(8, 1'b1);
        run(12, 1'b0);
        chk_int("press_count_en0", cnt0, 1);
        chk_int("press_count_en1", cnt1, 1);

        // bounce shorter than the debounce window
        cnt0 = 0; cnt1 = 0;
        run(3, 1'b1);
        run(1, 1'b0);
        run(3, 1'b1);
        run(12, 1'b0);
        chk_int("bounce_count_en0", cnt0, 0);
        chk_int("bounce_count_en1", cnt1, 0);

        // long hold with auto-repeat
        cnt0 = 0; cnt1 = 0;
        run(30, 1'b1);
        run(12, 1'b0);
        chk_int("hold_count_en0", cnt0, 1);
        chk_int("hold_count_en1", cnt1, 8);

        // release lands on the repeat expiry cycle
        cnt0 = 0; cnt1 = 0;
        run(19, 1'b1);
        run(12, 1'b0);
        chk_int("race_count_en1", cnt1, 4);

        // reset while repeating, button still held
        run(20, 1'b1);
        cnt0 = 0; cnt1 = 0;
        step(1'b1, 1'b1);
        chk("mid_rst_pulse", p1, 1'b0);
        chk("mid_rst_level", l1, 1'b0);
        run(10, 1'b1);
        run(12, 1'b0);
        chk_int("rst_repress_en0", cnt0, 1);
        chk_int("rst_repress_en1", cnt1, 1);

        // random runs of press/release with occasional resets
        for (int r = 0; r < 60; r++) begin
            lv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            rr  = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < len; i++) step(rr && i == 0, lv);
        end
        run(12, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_pulse.md
Name: button_pulse

Overview:
- Upstream conditioner for the two-digit score display.
- Takes one raw, bouncy push-button/switch input and produces a clean single-cycle increment pulse that drives the display counter's INC input.
- Adds optional hold-to-auto-repeat, so a held button keeps incrementing at a fixed rate.
- Also exports the debounced level for other game logic.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles the synchronized input must differ from the stable level before the change is accepted (10 ms at 25 MHz); must be >= 2.
- REPEAT_DELAY, 12500000, cycles from the first pulse to the first auto-repeat pulse while held; must be >= 2.
- REPEAT_PERIOD, 2500000, cycles between successive auto-repeat pulses; must be >= 2.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = exactly one pulse per press.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- SW  input  1  raw asynchronous button level, 1 = pressed.
- PULSE  output  1  registered, one-cycle-wide increment pulse.
- LEVEL  output  1  registered debounced button level.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high. While RST is sampled high:
  - synchronizer flops, LEVEL, PULSE and all counters clear to 0;
  - the FSM goes to IDLE.
- Input synchronizer: 2-flop synchronizer on SW (sync1, sync2); all logic downstream uses only sync2.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES)):
  - If sync2 == LEVEL: counter <= 0.
  - Otherwise the counter increments each cycle.
  - On the edge where the counter == DEBOUNCE_CYCLES-1 and sync2 still differs: LEVEL <= sync2 and counter <= 0.
  - Any bounce shorter than DEBOUNCE_CYCLES restarts the count. Press and release are filtered identically.
- Press latency: with SW sampled high at edge 0 and held, LEVEL rises after edge DEBOUNCE_CYCLES+1, and PULSE is high exactly between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
- FSM states are IDLE, HOLD and REPEAT. A single timer, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)), is cleared on every state change.
  - IDLE: when LEVEL == 1, PULSE <= 1, timer <= 0, go to HOLD.
  - HOLD: when LEVEL == 0, go to IDLE. Else, when REPEAT_EN == 1 and timer == REPEAT_DELAY-1, PULSE <= 1 and go to REPEAT. Else the timer increments.
  - REPEAT: when LEVEL == 0, go to IDLE. Else, when timer == REPEAT_PERIOD-1, PULSE <= 1 and timer <= 0. Else the timer increments.
  - With REPEAT_EN == 0, HOLD never leaves except on release, and the timer stays frozen at 0.
- PULSE is 0 in every cycle not listed above. PULSE is never high two consecutive cycles (guaranteed because all periods are >= 2).
- Repeat spacing: the first repeat pulse comes exactly REPEAT_DELAY cycles after the press pulse; later pulses are exactly REPEAT_PERIOD cycles apart.
- Simultaneous events:
  - Release beats expiry: if LEVEL falls on the same cycle the timer expires, no pulse is issued and the FSM goes to IDLE.
  - Reset beats everything.
- Reset mid-operation: PULSE drops immediately, state is lost. If SW is still held after RST deasserts, this counts as a new press: one pulse after the normal press latency.
- No pulse is ever generated on release.
- Counter wrap: no counter can pass its terminal value, because each is cleared on match.

Decomposition:
- constants.v gets:
  - the default timing values (DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD for the 25 MHz board clock);
  - FSM state encodings (IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2).
- One natural sub-module: debounce_filter (synchronizer plus debounce counter; ports CLK, RST, SW, LEVEL), reusable for the other board buttons.
- The FSM and timer stay in button_pulse.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press held 8 cycles, REPEAT_EN=0, SW high from edge 0 -> LEVEL=1 after edge 5; PULSE high only between edges 6 and 7; exactly 1 pulse; no pulse on release; LEVEL=0 six cycles after SW falls.
- Bounce: SW high 3 cycles, low 1, high 3, low -> LEVEL stays 0, PULSE never asserts.
- Long hold, REPEAT_EN=1, SW held 30 cycles -> pulses between edges 6/7, 16/17, 19/20, 22/23, …; spacing 10 then 3; release stops pulses within debounce latency.
- Release coinciding with repeat expiry (LEVEL falls on the cycle timer == REPEAT_PERIOD-1) -> no pulse; FSM in IDLE next cycle.
- RST asserted for 1 cycle while in REPEAT with SW held -> PULSE=0, LEVEL=0 the cycle after; one new pulse DEBOUNCE_CYCLES+3 edges after RST release.
- Reset values: RST held 3 cycles with SW toggling -> PULSE=0 and LEVEL=0 throughout and on the first cycle after release.
